// File: rtl/l2c_multi_ctrl_if.sv
// Signal bundle between l2c_multi_ctrl and its neighbours: L1 refill channels,
// write-buffer hazard flags and the shared L2-to-memory port.
interface l2c_multi_ctrl_if #(
  parameter int NUM_CH = 2
);
  localparam int OW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  // Handshake: level requests (l1_replace_req, mem_dirty_req, mem_replace_req) are held by
  // their source until the matching single-cycle response (replace_req/update_ena,
  // mem_dirty_done/mem_replace_done) is seen; a response with no pending request is ignored.
  logic [NUM_CH-1:0] l1_replace_req;
  logic [NUM_CH-1:0] miss;
  logic [NUM_CH-1:0] dirty;
  logic [NUM_CH-1:0] ack_sync;
  logic [NUM_CH-1:0] wb_read_tag_hit;
  logic              mem_dirty_done;
  logic              mem_replace_done;
  logic [NUM_CH-1:0] replace_req;
  logic [NUM_CH-1:0] update_ena;
  logic              mem_dirty_req;
  logic              mem_replace_req;
  logic [OW-1:0]     mem_owner;
  logic              mem_busy;
  logic [NUM_CH-1:0] ack_err;

  modport slave (
    input  l1_replace_req, miss, dirty, ack_sync, wb_read_tag_hit,
    input  mem_dirty_done, mem_replace_done,
    output replace_req, update_ena, mem_dirty_req, mem_replace_req,
    output mem_owner, mem_busy, ack_err
  );

  modport master (
    output l1_replace_req, miss, dirty, ack_sync, wb_read_tag_hit,
    output mem_dirty_done, mem_replace_done,
    input  replace_req, update_ena, mem_dirty_req, mem_replace_req,
    input  mem_owner, mem_busy, ack_err
  );
endinterface

// File: rtl/l2c_multi_ctrl.sv
// Multi-channel L2 miss controller: one replace/writeback FSM per L1 channel,
// all sharing a single memory port through a round-robin arbiter.
module l2c_multi_ctrl #(
  parameter int                NUM_CH      = 2,
  parameter logic [NUM_CH-1:0] WB_CHECK    = 2'b10,
  parameter int                ACK_TIMEOUT = 0,
  parameter int                TO_W        = 8
) (
  input  logic                clk_l2,
  input  logic                rst_n,
  l2c_multi_ctrl_if.slave     bus,
  output logic [3*NUM_CH-1:0] o_dbg_state
);
  localparam int OW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_ACK  = 3'd1,
    S_ARB       = 3'd2,
    S_M_DIRTY   = 3'd3,
    S_WB_WAIT   = 3'd4,
    S_M_REPLACE = 3'd5
  } state_t;

  state_t            r_state     [NUM_CH];
  state_t            w_state_nxt [NUM_CH];
  logic [TO_W-1:0]   r_to_cnt    [NUM_CH];
  logic [TO_W-1:0]   w_to_cnt_nxt[NUM_CH];
  logic [NUM_CH-1:0] r_replace_req, w_replace_req_nxt;
  logic [NUM_CH-1:0] r_update_ena,  w_update_ena_nxt;
  logic [NUM_CH-1:0] r_ack_err,     w_ack_err_nxt;
  logic [OW-1:0]     r_owner, w_owner_nxt;
  logic [OW-1:0]     r_rr,    w_rr_nxt;
  logic              r_busy,  w_busy_nxt;
  logic [NUM_CH-1:0] w_arb_mask;
  logic              w_gnt_vld;
  logic [OW-1:0]     w_gnt_idx;
  logic              w_mem_dirty_req, w_mem_replace_req;

  // Round-robin pick: lowest requester at or above r_rr, else lowest overall.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    for (int i = 0; i < NUM_CH; i++) w_arb_mask[i] = (r_state[i] == S_ARB);
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (w_arb_mask[i]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = OW'(i);
      end
    end
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (w_arb_mask[i] && (OW'(i) >= r_rr)) w_gnt_idx = OW'(i);
    end
    if (r_busy) w_gnt_vld = 1'b0;
  end

  always_comb begin
    w_busy_nxt        = r_busy;
    w_owner_nxt       = r_owner;
    w_rr_nxt          = r_rr;
    w_replace_req_nxt = '0;
    w_update_ena_nxt  = '0;
    w_ack_err_nxt     = r_ack_err;
    for (int i = 0; i < NUM_CH; i++) begin
      w_state_nxt[i]  = r_state[i];
      w_to_cnt_nxt[i] = '0;
      case (r_state[i])
        S_IDLE: begin
          if (bus.l1_replace_req[i]) begin
            if (bus.miss[i]) begin
              w_state_nxt[i]       = S_WAIT_ACK;
              w_replace_req_nxt[i] = 1'b1;
            end else begin
              w_update_ena_nxt[i]  = 1'b1;
            end
          end
        end
        S_WAIT_ACK: begin
          if (bus.ack_sync[i]) begin
            w_state_nxt[i] = S_ARB;
          end else if (ACK_TIMEOUT > 0) begin
            if (r_to_cnt[i] == TO_W'(ACK_TIMEOUT - 1)) begin
              w_ack_err_nxt[i] = 1'b1;
              w_state_nxt[i]   = S_ARB;
            end else begin
              w_to_cnt_nxt[i]  = r_to_cnt[i] + 1'b1;
            end
          end
        end
        S_ARB: begin
          if (w_gnt_vld && (w_gnt_idx == OW'(i))) begin
            w_state_nxt[i] = bus.dirty[i] ? S_M_DIRTY : S_M_REPLACE;
            w_busy_nxt     = 1'b1;
            w_owner_nxt    = w_gnt_idx;
            w_rr_nxt       = (w_gnt_idx == OW'(NUM_CH - 1)) ? '0 : w_gnt_idx + OW'(1);
          end
        end
        S_M_DIRTY: begin
          if (r_busy && (r_owner == OW'(i)) && bus.mem_dirty_done)
            w_state_nxt[i] = (WB_CHECK[i] && bus.wb_read_tag_hit[i]) ? S_WB_WAIT : S_M_REPLACE;
        end
        S_WB_WAIT: begin
          if (!bus.wb_read_tag_hit[i]) w_state_nxt[i] = S_M_REPLACE;
        end
        S_M_REPLACE: begin
          if (r_busy && (r_owner == OW'(i)) && bus.mem_replace_done) begin
            w_state_nxt[i]      = S_IDLE;
            w_update_ena_nxt[i] = 1'b1;
            w_busy_nxt          = 1'b0;
          end
        end
        default: w_state_nxt[i] = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_l2 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_state[i]  <= S_IDLE;
        r_to_cnt[i] <= '0;
      end
      r_replace_req <= '0;
      r_update_ena  <= '0;
      r_ack_err     <= '0;
      r_owner       <= '0;
      r_rr          <= '0;
      r_busy        <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_state[i]  <= w_state_nxt[i];
        r_to_cnt[i] <= w_to_cnt_nxt[i];
      end
      r_replace_req <= w_replace_req_nxt;
      r_update_ena  <= w_update_ena_nxt;
      r_ack_err     <= w_ack_err_nxt;
      r_owner       <= w_owner_nxt;
      r_rr          <= w_rr_nxt;
      r_busy        <= w_busy_nxt;
    end
  end

  // Memory requests follow the owner's registered state, so they can never overlap.
  always_comb begin
    w_mem_dirty_req   = 1'b0;
    w_mem_replace_req = 1'b0;
    o_dbg_state       = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      o_dbg_state[3*i +: 3] = r_state[i];
      if (r_busy && (r_owner == OW'(i))) begin
        w_mem_dirty_req   = (r_state[i] == S_M_DIRTY);
        w_mem_replace_req = (r_state[i] == S_M_REPLACE);
      end
    end
  end

  assign bus.replace_req     = r_replace_req;
  assign bus.update_ena      = r_update_ena;
  assign bus.ack_err         = r_ack_err;
  assign bus.mem_owner       = r_owner;
  assign bus.mem_busy        = r_busy;
  assign bus.mem_dirty_req   = w_mem_dirty_req;
  assign bus.mem_replace_req = w_mem_replace_req;
endmodule

// File: tb/tb_l2c_multi_ctrl.sv
// Bench for l2c_multi_ctrl: directed scenarios plus randomized rounds checked
// against a transaction-level model of grant order, hazards and error flags.
module tb_l2c_multi_ctrl;
  localparam int         NUM_CH      = 2;
  localparam logic [1:0] WB_CHECK    = 2'b10;
  localparam int         ACK_TIMEOUT = 4;

  logic clk_l2 = 1'b0;
  logic rst_n  = 1'b0;
  logic [3*NUM_CH-1:0] dbg_state;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_l2 = ~clk_l2;

  l2c_multi_ctrl_if #(.NUM_CH(NUM_CH)) bus ();

  l2c_multi_ctrl #(
    .NUM_CH(NUM_CH), .WB_CHECK(WB_CHECK), .ACK_TIMEOUT(ACK_TIMEOUT), .TO_W(8)
  ) dut (
    .clk_l2(clk_l2), .rst_n(rst_n), .bus(bus), .o_dbg_state(dbg_state)
  );

  // {replace_req, update_ena, mem_dirty_req, mem_replace_req, mem_owner, mem_busy, ack_err}
  function automatic logic [9:0] obs();
    return {bus.replace_req, bus.update_ena, bus.mem_dirty_req, bus.mem_replace_req,
            bus.mem_owner, bus.mem_busy, bus.ack_err};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk_l2);
    #1;
  endtask

  task automatic clear_inputs();
    bus.l1_replace_req = '0; bus.miss = '0; bus.dirty = '0; bus.ack_sync = '0;
    bus.wb_read_tag_hit = '0; bus.mem_dirty_done = 1'b0; bus.mem_replace_done = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [9:0] e;
    rst_n = 1'b0;
    clear_inputs();
    step(2);
    e = '0;
    n_tests++; if (obs() !== e) begin n_fail++; $display("FAIL reset_outputs got=%b exp=%b", obs(), e); end
    n_tests++; if (dbg_state !== 6'd0) begin n_fail++; $display("FAIL reset_state got=%b exp=000000", dbg_state); end
    rst_n = 1'b1;
  endtask

  task automatic test_hit();
    logic [9:0] e;
    do_reset();
    bus.l1_replace_req = 2'b01; bus.miss = 2'b00;
    step(1);
    e = {2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
    n_tests++; if (obs() !== e) begin n_fail++; $display("FAIL hit_c1 got=%b exp=%b", obs(), e); end
    bus.l1_replace_req = 2'b00;
    step(1);
    e = '0;
    n_tests++; if (obs() !== e) begin n_fail++; $display("FAIL hit_c2 got=%b exp=%b", obs(), e); end
    n_tests++; if (dbg_state[2:0] !== 3'd0) begin n_fail++; $display("FAIL hit_idle got=%0d exp=0", dbg_state[2:0]); end
  endtask

  task automatic test_clean_miss();
    logic [9:0] e;
    do_reset();
    bus.l1_replace_req = 2'b10; bus.miss = 2'b10; bus.dirty = 2'b00;
    step(1);
    e = {2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
    n_tests++; if (obs() !== e) begin n_fail++; $display("FAIL miss_c1 got=%b exp=%b", obs(), e); end
    bus.l1_replace_req = 2'b00; bus.miss = 2'b00;
    step(2);
    bus.ack_sync = 2'b10;
    step(1);
    bus.ack_sync = 2'b00;
    e = '0;
    n_tests++; if (obs() !== e) begin n_fail++; $display("FAIL miss_c4 got=%b exp=%b", obs(), e); end
    step(1);
    e = {2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00};
    n_tests++; if (obs() !== e) begin n_fail++; $display("FAIL miss_c5 got=%b exp=%b", obs(), e); end
    step(4);
    n_tests++; if (obs() !== e) begin n_fail++; $display("FAIL miss_c9 got=%b exp=%b", obs(), e); end
    bus.mem_replace_done = 1'b1;
    step(1);
    bus.mem_replace_done = 1'b0;
    e = {2'b00, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00};
    n_tests++; if (obs() !== e) begin n_fail++; $display("FAIL miss_c10 got=%b exp=%b", obs(), e); end
    step(1);
    e = {2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00};
    n_tests++; if (obs() !== e) begin n_fail++; $display("FAIL miss_c11 got=%b exp=%b", obs(), e); end
  endtask

  task automatic test_dirty_wb(input int ch);
    logic [9:0] e;
    logic [1:0] m;
    logic own;
    m = 2'b01 << ch;
    own = (ch == 1);
    do_reset();
    bus.l1_replace_req = m; bus.miss = m; bus.dirty = m; bus.wb_read_tag_hit = m;
    step(1);
    bus.l1_replace_req = 2'b00; bus.miss = 2'b00;
    step(1);
    bus.ack_sync = m;
    step(1);
    bus.ack_sync = 2'b00;
    step(1);
    e = {2'b00, 2'b00, 1'b1, 1'b0, own, 1'b1, 2'b00};
    n_tests++; if (obs() !== e) begin n_fail++; $display("FAIL dirty_req_ch%0d got=%b exp=%b", ch, obs(), e); end
    bus.mem_dirty_done = 1'b1;
    step(1);
    bus.mem_dirty_done = 1'b0;
    if (WB_CHECK[ch]) begin
      e = {2'b00, 2'b00, 1'b0, 1'b0, own, 1'b1, 2'b00};
      n_tests++; if (obs() !== e) begin n_fail++; $display("FAIL wb_wait_ch%0d got=%b exp=%b", ch, obs(), e); end
      step(1);
      n_tests++; if (obs() !== e) begin n_fail++; $display("FAIL wb_hold_ch%0d got=%b exp=%b", ch, obs(), e); end
      bus.wb_read_tag_hit = 2'b00;
      step(1);
    end
    e = {2'b00, 2'b00, 1'b0, 1'b1, own, 1'b1, 2'b00};
    n_tests++; if (obs() !== e) begin n_fail++; $display("FAIL dirty_fill_ch%0d got=%b exp=%b", ch, obs(), e); end
    bus.mem_replace_done = 1'b1;
    step(1);
    bus.mem_replace_done = 1'b0;
    e = {2'b00, m, 1'b0, 1'b0, own, 1'b0, 2'b00};
    n_tests++; if (obs() !== e) begin n_fail++; $display("FAIL dirty_done_ch%0d got=%b exp=%b", ch, obs(), e); end
    clear_inputs();
  endtask

  task automatic contend(input logic [1:0] mask, input logic first);
    logic [9:0] e;
    logic second;
    second = ~first;
    bus.l1_replace_req = mask; bus.miss = mask; bus.dirty = 2'b00;
    step(1);
    bus.l1_replace_req = 2'b00; bus.miss = 2'b00;
    step(1);
    bus.ack_sync = mask;
    step(1);
    bus.ack_sync = 2'b00;
    step(1);
    e = {2'b00, 2'b00, 1'b0, 1'b1, first, 1'b1, 2'b00};
    n_tests++; if (obs() !== e) begin n_fail++; $display("FAIL arb_first got=%b exp=%b", obs(), e); end
    bus.mem_replace_done = 1'b1;
    step(1);
    bus.mem_replace_done = 1'b0;
    e = {2'b00, 2'b01 << first, 1'b0, 1'b0, first, 1'b0, 2'b00};
    n_tests++; if (obs() !== e) begin n_fail++; $display("FAIL arb_release got=%b exp=%b", obs(), e); end
    if (mask == 2'b11) begin
      step(1);
      e = {2'b00, 2'b00, 1'b0, 1'b1, second, 1'b1, 2'b00};
      n_tests++; if (obs() !== e) begin n_fail++; $display("FAIL arb_second got=%b exp=%b", obs(), e); end
      bus.mem_replace_done = 1'b1;
      step(1);
      bus.mem_replace_done = 1'b0;
      e = {2'b00, 2'b01 << second, 1'b0, 1'b0, second, 1'b0, 2'b00};
      n_tests++; if (obs() !== e) begin n_fail++; $display("FAIL arb_release2 got=%b exp=%b", obs(), e); end
    end
    step(1);
  endtask

  task automatic test_arbitration();
    do_reset();
    contend(2'b11, 1'b0);
    contend(2'b01, 1'b0);
    contend(2'b11, 1'b1);
  endtask

  task automatic test_timeout();
    logic [9:0] e;
    do_reset();
    bus.l1_replace_req = 2'b01; bus.miss = 2'b01;
    step(1);
    bus.l1_replace_req = 2'b00; bus.miss = 2'b00;
    step(3);
    e = '0;
    n_tests++; if (obs() !== e) begin n_fail++; $display("FAIL to_before got=%b exp=%b", obs(), e); end
    n_tests++; if (dbg_state[2:0] !== 3'd1) begin n_fail++; $display("FAIL to_wait_state got=%0d exp=1", dbg_state[2:0]); end
    step(1);
    e = {2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01};
    n_tests++; if (obs() !== e) begin n_fail++; $display("FAIL to_err got=%b exp=%b", obs(), e); end
    step(1);
    e = {2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01};
    n_tests++; if (obs() !== e) begin n_fail++; $display("FAIL to_fill got=%b exp=%b", obs(), e); end
    bus.mem_replace_done = 1'b1;
    step(1);
    bus.mem_replace_done = 1'b0;
    e = {2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01};
    n_tests++; if (obs() !== e) begin n_fail++; $display("FAIL to_done got=%b exp=%b", obs(), e); end
    step(3);
    e = {2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01};
    n_tests++; if (obs() !== e) begin n_fail++; $display("FAIL to_sticky got=%b exp=%b", obs(), e); end
  endtask

  // Follows test_timeout without a reset so the sticky flag is still set on entry.
  task automatic test_reset_mid();
    logic [9:0] e;
    bus.l1_replace_req = 2'b10; bus.miss = 2'b10; bus.dirty = 2'b00;
    step(1);
    bus.l1_replace_req = 2'b00; bus.miss = 2'b00;
    step(1);
    bus.ack_sync = 2'b10;
    step(1);
    bus.ack_sync = 2'b00;
    step(1);
    e = {2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 2'b01};
    n_tests++; if (obs() !== e) begin n_fail++; $display("FAIL rstmid_fill got=%b exp=%b", obs(), e); end
    #2;
    rst_n = 1'b0;
    #1;
    e = '0;
    n_tests++; if (obs() !== e) begin n_fail++; $display("FAIL rstmid_async got=%b exp=%b", obs(), e); end
    n_tests++; if (dbg_state !== 6'd0) begin n_fail++; $display("FAIL rstmid_state got=%b exp=000000", dbg_state); end
    step(2);
    rst_n = 1'b1;
    bus.mem_replace_done = 1'b1;
    step(1);
    bus.mem_replace_done = 1'b0;
    n_tests++; if (obs() !== e) begin n_fail++; $display("FAIL rstmid_stray1 got=%b exp=%b", obs(), e); end
    step(1);
    n_tests++; if (obs() !== e) begin n_fail++; $display("FAIL rstmid_stray2 got=%b exp=%b", obs(), e); end
  endtask

  task automatic test_random();
    logic [1:0] exp_q[$];
    logic [1:0] rq, ms, dt, ht, model_err, ev;
    int model_rr, last, d, c, haz_exp, haz_seen, ch;
    int upd_cnt[2];
    bit to_round, excl_bad, prev_busy, prev_dreq, fin;
    do_reset();
    model_rr = 0;
    model_err = 2'b00;
    for (int r = 0; r < 40; r++) begin
      rq = 2'($urandom_range(1, 3));
      ms = 2'($urandom_range(0, 3)) & rq;
      dt = 2'($urandom_range(0, 3));
      ht = 2'($urandom_range(0, 3));
      to_round = ($urandom_range(0, 4) == 0);
      d = $urandom_range(0, 2);
      exp_q.delete();
      haz_exp = 0; haz_seen = 0; last = -1;
      // Grants go in rotating order from the round-robin pointer.
      for (int k = 0; k < 2; k++) begin
        ch = (model_rr + k) % 2;
        if (ms[ch]) begin
          ev = {ch[0], dt[ch]};
          exp_q.push_back(ev);
          if (dt[ch] && WB_CHECK[ch] && ht[ch]) haz_exp++;
          last = ch;
        end
      end
      if (last >= 0) model_rr = (last + 1) % 2;
      if (to_round) model_err = model_err | ms;
      bus.l1_replace_req = rq; bus.miss = ms; bus.dirty = dt; bus.wb_read_tag_hit = ht;
      step(1);
      n_tests++; if (bus.replace_req !== ms) begin n_fail++; $display("FAIL rnd_replace_req r=%0d got=%b exp=%b", r, bus.replace_req, ms); end
      bus.l1_replace_req = 2'b00; bus.miss = 2'b00;
      c = 1; upd_cnt[0] = 0; upd_cnt[1] = 0;
      excl_bad = 0; prev_busy = 0; prev_dreq = 0; fin = 0;
      while (!fin) begin
        for (int k = 0; k < 2; k++) if (bus.update_ena[k]) upd_cnt[k]++;
        if (bus.mem_dirty_req && bus.mem_replace_req) excl_bad = 1;
        if (bus.mem_busy && !prev_busy) begin
          n_tests++;
          if (exp_q.size() == 0) begin
            n_fail++; $display("FAIL rnd_grant r=%0d got owner=%0d exp no grant", r, bus.mem_owner);
          end else begin
            ev = exp_q.pop_front();
            if ({bus.mem_owner, bus.mem_dirty_req} !== ev) begin
              n_fail++; $display("FAIL rnd_grant r=%0d got {owner,dirty}=%b exp=%b", r, {bus.mem_owner, bus.mem_dirty_req}, ev);
            end
          end
        end
        if (bus.mem_busy && prev_busy && prev_dreq && !bus.mem_dirty_req && !bus.mem_replace_req) haz_seen++;
        bus.ack_sync = (!to_round && c == 1 + d) ? ms : 2'b00;
        bus.mem_dirty_done   = bus.mem_dirty_req && ($urandom_range(0, 2) == 0);
        bus.mem_replace_done = bus.mem_replace_req && ($urandom_range(0, 2) == 0);
        if (bus.mem_busy && !bus.mem_dirty_req && !bus.mem_replace_req && ($urandom_range(0, 1) == 1))
          bus.wb_read_tag_hit[bus.mem_owner] = 1'b0;
        prev_busy = bus.mem_busy;
        prev_dreq = bus.mem_dirty_req;
        step(1);
        c++;
        if (c >= 8 && exp_q.size() == 0 && !bus.mem_busy && upd_cnt[0] + upd_cnt[1] >= int'(rq[0]) + int'(rq[1])) fin = 1;
        if (c > 300) begin
          fin = 1;
          n_tests++; n_fail++;
          $display("FAIL rnd_budget r=%0d got %0d cycles exp completion within 300", r, c);
        end
      end
      clear_inputs();
      n_tests++; if (upd_cnt[0] !== int'(rq[0]) || upd_cnt[1] !== int'(rq[1])) begin
        n_fail++; $display("FAIL rnd_update r=%0d got=%0d/%0d exp=%0d/%0d", r, upd_cnt[1], upd_cnt[0], rq[1], rq[0]);
      end
      n_tests++; if (haz_seen !== haz_exp) begin n_fail++; $display("FAIL rnd_hazard r=%0d got=%0d exp=%0d", r, haz_seen, haz_exp); end
      n_tests++; if (excl_bad !== 1'b0) begin n_fail++; $display("FAIL rnd_exclusive r=%0d got=1 exp=0", r); end
      n_tests++; if (bus.ack_err !== model_err) begin n_fail++; $display("FAIL rnd_ack_err r=%0d got=%b exp=%b", r, bus.ack_err, model_err); end
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_hit();
    test_clean_miss();
    test_dirty_wb(1);
    test_dirty_wb(0);
    test_arbitration();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end
endmodule
